// File: rtl/hwpe_tcdm_arb_pkg.sv
// Shared sizing, request payload type and round-robin helper for the TCDM port arbiter.
package hwpe_tcdm_arb_pkg;

    localparam int unsigned N_MASTERS       = 2;
    localparam int unsigned N_PORTS         = 4;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned BE_W            = DATA_W / 8;
    localparam int unsigned MAX_OUTSTANDING = 2;
    localparam int unsigned OWNER_W         = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] add;
        logic              wen;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } tcdm_req_t;

    // First requesting master at or after ptr, searching cyclically; ptr when nobody requests.
    function automatic logic [OWNER_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req_vec,
                                                   input logic [OWNER_W-1:0]   ptr);
        logic [OWNER_W-1:0] pick;
        logic               found;
        int unsigned        idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            idx = (32'(ptr) + i) % N_MASTERS;
            if (!found && req_vec[idx]) begin
                pick  = OWNER_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/hwpe_tcdm_port_arbiter_if.sv
// TCDM request/response bundle of N_CH channels; master drives requests, slave answers.
interface hwpe_tcdm_port_arbiter_if
    import hwpe_tcdm_arb_pkg::*;
#(
    parameter int unsigned N_CH = N_PORTS
);

    logic [N_CH-1:0]             req;
    logic [N_CH-1:0][ADDR_W-1:0] add;
    logic [N_CH-1:0]             wen;
    logic [N_CH-1:0][BE_W-1:0]   be;
    logic [N_CH-1:0][DATA_W-1:0] data;
    logic [N_CH-1:0]             gnt;
    logic [N_CH-1:0]             r_valid;
    logic [N_CH-1:0][DATA_W-1:0] r_data;

    modport master (output req, add, wen, be, data, input  gnt, r_valid, r_data);
    modport slave  (input  req, add, wen, be, data, output gnt, r_valid, r_data);

endinterface

// File: rtl/tcdm_arb_owner_fifo.sv
// Circular FIFO of response owners; pointers wrap at DEPTH, caller never pushes full or pops empty.
module tcdm_arb_owner_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/hwpe_tcdm_port_arbiter.sv
// Per-port round-robin sharing of TCDM channels between masters, with in-order response routing.
module hwpe_tcdm_port_arbiter
    import hwpe_tcdm_arb_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    hwpe_tcdm_port_arbiter_if.slave  m,
    hwpe_tcdm_port_arbiter_if.master s,
    output logic                     err_o
);

    logic [N_PORTS-1:0] spur;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic [N_MASTERS-1:0] req_vec;
        tcdm_req_t            cand [N_MASTERS];
        tcdm_req_t            sel;
        logic [OWNER_W-1:0]   rr_ptr;
        logic                 lock_vld;
        logic [OWNER_W-1:0]   lock_own;
        logic [OWNER_W-1:0]   winner;
        logic [OWNER_W-1:0]   head;
        logic                 win_req;
        logic                 hs;
        logic                 pop;
        logic                 full;
        logic                 empty;

        for (genvar mi = 0; mi < N_MASTERS; mi++) begin : g_m
            localparam int IDX = mi * N_PORTS + p;
            assign req_vec[mi]      = m.req[IDX];
            assign cand[mi]         = '{add: m.add[IDX], wen: m.wen[IDX], be: m.be[IDX], data: m.data[IDX]};
            assign m.gnt[IDX]       = hs & (winner == OWNER_W'(mi));
            assign m.r_valid[IDX]   = pop & (head == OWNER_W'(mi));
            assign m.r_data[IDX]    = s.r_data[p];
        end

        // A winner left waiting for a grant keeps the port until it is served.
        assign winner  = (lock_vld && req_vec[lock_own]) ? lock_own : rr_pick(req_vec, rr_ptr);
        assign win_req = req_vec[winner];
        assign sel     = win_req ? cand[winner] : '0;

        assign s.req[p]  = win_req & ~full;
        assign s.add[p]  = sel.add;
        assign s.wen[p]  = sel.wen;
        assign s.be[p]   = sel.be;
        assign s.data[p] = sel.data;

        assign hs      = s.req[p] & s.gnt[p];
        assign pop     = s.r_valid[p] & ~empty;
        assign spur[p] = s.r_valid[p] & empty;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rr_ptr   <= '0;
                lock_vld <= 1'b0;
                lock_own <= '0;
            end else if (hs) begin
                rr_ptr   <= (winner == OWNER_W'(N_MASTERS - 1)) ? '0 : winner + OWNER_W'(1);
                lock_vld <= 1'b0;
            end else if (s.req[p]) begin
                lock_vld <= 1'b1;
                lock_own <= winner;
            end else begin
                lock_vld <= 1'b0;
            end
        end

        tcdm_arb_owner_fifo #(
            .DEPTH (MAX_OUTSTANDING),
            .WIDTH (OWNER_W)
        ) u_owner_fifo (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .push   (hs),
            .pop    (pop),
            .wdata  (winner),
            .rdata  (head),
            .full   (full),
            .empty  (empty)
        );
    end

    // Sticky flag for a response that arrives with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    err_o <= 1'b0;
        else if (|spur) err_o <= 1'b1;
    end

endmodule

// File: tb/tb_hwpe_tcdm_port_arbiter.sv
// Directed bench for hwpe_tcdm_port_arbiter: single master, contention, backpressure, full, error, reset.
module tb_hwpe_tcdm_port_arbiter;
    import hwpe_tcdm_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;
    int   checks = 0;
    int   failures = 0;

    hwpe_tcdm_port_arbiter_if #(.N_CH(N_MASTERS * N_PORTS)) m_if ();
    hwpe_tcdm_port_arbiter_if #(.N_CH(N_PORTS))             s_if ();

    hwpe_tcdm_port_arbiter dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .m      (m_if),
        .s      (s_if),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    function automatic int ix(input int mi, input int p);
        return mi * N_PORTS + p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int mi, input int p, input logic req, input logic [31:0] add, input logic wen);
        m_if.req[ix(mi, p)]  = req;
        m_if.add[ix(mi, p)]  = add;
        m_if.wen[ix(mi, p)]  = wen;
        m_if.be[ix(mi, p)]   = req ? 4'hF : 4'h0;
        m_if.data[ix(mi, p)] = req ? add ^ 32'h5A5A_5A5A : 32'h0;
    endtask

    task automatic idle();
        m_if.req     = '0;
        m_if.add     = '0;
        m_if.wen     = '0;
        m_if.be      = '0;
        m_if.data    = '0;
        s_if.gnt     = '0;
        s_if.r_valid = '0;
        s_if.r_data  = '0;
    endtask

    logic [4:0] eg0, eg1, er0, er1;

    initial begin
        idle();
        #2;
        // Reset state
        chk("rst_err",     32'(err), 32'h0);
        chk("rst_sreq",    32'(s_if.req), 32'h0);
        chk("rst_gnt",     32'(m_if.gnt), 32'h0);
        chk("rst_rvalid",  32'(m_if.r_valid), 32'h0);
        chk("idle_sadd1",  s_if.add[1], 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1. Single master read on port 0
        tick();
        drive(0, 0, 1'b1, 32'h1000, 1'b1);
        s_if.gnt[0] = 1'b1;
        #1;
        chk("t1_sreq0",   32'(s_if.req[0]), 32'h1);
        chk("t1_sadd0",   s_if.add[0], 32'h1000);
        chk("t1_swen0",   32'(s_if.wen[0]), 32'h1);
        chk("t1_gnt_m0",  32'(m_if.gnt[ix(0, 0)]), 32'h1);
        chk("t1_gnt_m1",  32'(m_if.gnt[ix(1, 0)]), 32'h0);
        tick();
        idle();
        s_if.r_valid[0] = 1'b1;
        s_if.r_data[0]  = 32'hDEADBEEF;
        #1;
        chk("t1_rv_m0",   32'(m_if.r_valid[ix(0, 0)]), 32'h1);
        chk("t1_rd_m0",   m_if.r_data[ix(0, 0)], 32'hDEADBEEF);
        chk("t1_rv_m1",   32'(m_if.r_valid[ix(1, 0)]), 32'h0);
        tick();
        idle();
        chk("t1_err",     32'(err), 32'h0);

        // 2. Contention on port 2 with 1-cycle responses
        eg0 = 5'b00101; eg1 = 5'b01010; er0 = 5'b01010; er1 = 5'b10100;
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c < 4) begin
                drive(0, 2, 1'b1, 32'h2000, 1'b1);
                drive(1, 2, 1'b1, 32'h2100, 1'b1);
                s_if.gnt[2] = 1'b1;
            end
            if (c > 0) begin
                s_if.r_valid[2] = 1'b1;
                s_if.r_data[2]  = 32'hC0DE_0000 + 32'(c);
            end
            #1;
            chk($sformatf("t2_gnt_m0_c%0d", c), 32'(m_if.gnt[ix(0, 2)]), 32'(eg0[c]));
            chk($sformatf("t2_gnt_m1_c%0d", c), 32'(m_if.gnt[ix(1, 2)]), 32'(eg1[c]));
            chk($sformatf("t2_rv_m0_c%0d", c),  32'(m_if.r_valid[ix(0, 2)]), 32'(er0[c]));
            chk($sformatf("t2_rv_m1_c%0d", c),  32'(m_if.r_valid[ix(1, 2)]), 32'(er1[c]));
            if (c > 0) chk($sformatf("t2_rd_c%0d", c), m_if.r_data[ix(c % 2 == 1 ? 0 : 1, 2)], 32'hC0DE_0000 + 32'(c));
            tick();
        end
        idle();

        // 3. Backpressure on port 1: m1 keeps the port while m0 joins
        drive(1, 1, 1'b1, 32'hB000, 1'b1);
        #1;
        chk("t3_sadd_a",  s_if.add[1], 32'hB000);
        chk("t3_gnt_a",   32'(m_if.gnt), 32'h0);
        tick();
        drive(0, 1, 1'b1, 32'hA000, 1'b1);
        #1;
        chk("t3_sadd_b",  s_if.add[1], 32'hB000);
        tick();
        #1;
        chk("t3_sadd_c",  s_if.add[1], 32'hB000);
        chk("t3_sreq_c",  32'(s_if.req[1]), 32'h1);
        tick();
        s_if.gnt[1] = 1'b1;
        #1;
        chk("t3_gnt_m1",  32'(m_if.gnt[ix(1, 1)]), 32'h1);
        chk("t3_gnt_m0",  32'(m_if.gnt[ix(0, 1)]), 32'h0);
        tick();
        drive(1, 1, 1'b0, 32'h0, 1'b0);
        s_if.r_valid[1] = 1'b1;
        #1;
        chk("t3_gnt2_m0", 32'(m_if.gnt[ix(0, 1)]), 32'h1);
        chk("t3_rv_m1",   32'(m_if.r_valid[ix(1, 1)]), 32'h1);
        chk("t3_rv_m0",   32'(m_if.r_valid[ix(0, 1)]), 32'h0);
        tick();
        idle();
        s_if.r_valid[1] = 1'b1;
        #1;
        chk("t3_rv2_m0",  32'(m_if.r_valid[ix(0, 1)]), 32'h1);
        tick();
        idle();

        // 4. Full owner FIFO on port 3
        drive(0, 3, 1'b1, 32'h3000, 1'b0);
        s_if.gnt[3] = 1'b1;
        #1;
        chk("t4_sreq_1",  32'(s_if.req[3]), 32'h1);
        tick();
        #1;
        chk("t4_gnt_2",   32'(m_if.gnt[ix(0, 3)]), 32'h1);
        tick();
        s_if.r_valid[3] = 1'b1;
        #1;
        chk("t4_sreq_full", 32'(s_if.req[3]), 32'h0);
        chk("t4_gnt_full",  32'(m_if.gnt[ix(0, 3)]), 32'h0);
        chk("t4_rv_full",   32'(m_if.r_valid[ix(0, 3)]), 32'h1);
        tick();
        s_if.r_valid[3] = 1'b0;
        #1;
        chk("t4_sreq_after", 32'(s_if.req[3]), 32'h1);
        tick();
        idle();
        s_if.r_valid[3] = 1'b1;
        #1;
        chk("t4_drain1",  32'(m_if.r_valid[ix(0, 3)]), 32'h1);
        tick();
        #1;
        chk("t4_drain2",  32'(m_if.r_valid[ix(0, 3)]), 32'h1);
        tick();
        idle();
        chk("t4_err",     32'(err), 32'h0);

        // 5. Spurious response on port 0
        s_if.r_valid[0] = 1'b1;
        s_if.r_data[0]  = 32'h1234_5678;
        #1;
        chk("t5_rv",      32'(m_if.r_valid), 32'h0);
        tick();
        idle();
        chk("t5_err",     32'(err), 32'h1);
        tick();
        tick();
        chk("t5_err_held", 32'(err), 32'h1);

        // 6. Reset with two outstanding on port 0
        drive(0, 0, 1'b1, 32'h4000, 1'b1);
        s_if.gnt[0] = 1'b1;
        #1;
        chk("t6_gnt_1",   32'(m_if.gnt[ix(0, 0)]), 32'h1);
        tick();
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_err",   32'(err), 32'h0);
        chk("t6_rst_sreq",  32'(s_if.req), 32'h0);
        chk("t6_rst_gnt",   32'(m_if.gnt), 32'h0);
        chk("t6_rst_rv",    32'(m_if.r_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        s_if.r_valid[0] = 1'b1;
        #1;
        chk("t6_late_rv", 32'(m_if.r_valid), 32'h0);
        tick();
        idle();
        chk("t6_late_err", 32'(err), 32'h1);
        drive(0, 0, 1'b1, 32'h5000, 1'b1);
        drive(1, 0, 1'b1, 32'h5100, 1'b1);
        s_if.gnt[0] = 1'b1;
        #1;
        chk("t6_first_m0", 32'(m_if.gnt[ix(0, 0)]), 32'h1);
        chk("t6_first_m1", 32'(m_if.gnt[ix(1, 0)]), 32'h0);
        chk("t6_first_add", s_if.add[0], 32'h5000);
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
